// File: rtl/mem_arb.sv
// Single-port memory arbiter sharing one memory port between fetch and data requesters.
// Latency: grant in cycle T, mem_en in T+1, rvalid/rdata in T+1+MEM_LAT, idle again in T+2+MEM_LAT.
// Backpressure: req/gnt handshake; requests are held until granted, grants only issue in IDLE.
module mem_arb #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Wait counter holds MEM_LAT-1; keep at least one bit when MEM_LAT is 1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic            own_dm_q;   // 1 = data path owns the in-flight transaction
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   starve_q;
  logic [SW-1:0]   starve_d;
  logic            starve_full;
  logic            idle;
  logic            wait_done;

  assign idle        = (state_q == IDLE);
  assign starve_full = (starve_q == SW'(STARVE_MAX));

  // Data has priority unless fetch has been passed over STARVE_MAX times in a row.
  assign if_gnt = idle && if_req && (!dm_req || starve_full);
  assign dm_gnt = idle && dm_req && !(if_req && starve_full);

  assign wait_done = (state_q == WAIT) && (cnt_q == '0);
  assign if_rvalid = wait_done && !own_dm_q;
  assign dm_rvalid = wait_done && own_dm_q;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  // Write completions carry no data.
  assign dm_rdata  = (dm_rvalid && !we_q) ? mem_rdata : '0;

  assign mem_en    = (state_q == CMD);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = !idle;

  // Starvation counter next value: bump on a data grant that overtakes a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (dm_gnt) begin
      if (!if_req)          starve_d = '0;
      else if (!starve_full) starve_d = starve_q + 1'b1;
    end
  end

  // Transaction FSM with latched command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      own_dm_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (dm_gnt) begin
            own_dm_q <= 1'b1;
            we_q     <= dm_we;
            addr_q   <= dm_addr;
            wdata_q  <= dm_wdata;
            state_q  <= CMD;
          end else if (if_gnt) begin
            own_dm_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= if_addr;
            wdata_q  <= '0;
            state_q  <= CMD;
          end
        end
        CMD: begin
          cnt_q   <= CW'(MEM_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
